// File: rtl/mc_fetch_unit.sv
// Purpose: PC owner and instruction fetcher; issues PC to imem over req/ack, latches IR, commits next PC.
// Latency: o_imem_req rises 1 cycle after i_start; o_ir/o_ir_valid update 1 cycle after i_imem_ack.
// Backpressure: imem stalls by withholding i_imem_ack; req/addr and PC are held frozen until it arrives.
//
// Ports:
//   i_clk, i_rst_n                 clock (rising edge), async active-low reset
//   i_start                        fetch request from the control FSM (ignored while a fetch is outstanding)
//   i_pc_we, i_pc_sel              commit next PC: 00 seq, 01 branch, 10 jump, 11 jr
//   i_branch_off, i_jump_idx,
//   i_jr_target                    next-PC operands
//   o_imem_req, o_imem_addr        fetch request and address to imem
//   i_imem_ack, i_imem_data        imem response
//   o_ir, o_ir_valid               instruction register and its qualifier
//   o_pc, o_pc_plus4               current PC, PC+4 of last fetched instruction
//   o_busy                         fetch outstanding
//   o_misalign                     1-cycle pulse on a rejected unaligned jr target
module mc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_pc_we,
  input  logic [1:0]  i_pc_sel,
  input  logic [31:0] i_branch_off,
  input  logic [25:0] i_jump_idx,
  input  logic [31:0] i_jr_target,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_data,
  output logic [31:0] o_ir,
  output logic        o_ir_valid,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus4,
  output logic        o_busy,
  output logic        o_misalign
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [31:0] next_pc;
  logic        we_ok;        // PC write allowed in this state
  logic        jr_bad;       // jr to a non-word-aligned target
  logic        pc_commit;
  logic [31:0] pc_new;       // PC as it will be after this edge
  logic        start_fetch;
  logic        ack_take;

  // Next-PC selection; everything wraps mod 2^32.
  always_comb begin
    next_pc = o_pc_plus4;
    case (i_pc_sel)
      2'b00:   next_pc = o_pc_plus4;
      2'b01:   next_pc = o_pc_plus4 + {i_branch_off[29:0], 2'b00};
      2'b10:   next_pc = {o_pc_plus4[31:28], i_jump_idx, 2'b00};
      default: next_pc = i_jr_target;
    endcase
  end

  assign we_ok       = i_pc_we && (state != REQ);
  assign jr_bad      = (i_pc_sel == 2'b11) && (i_jr_target[1:0] != 2'b00);
  assign pc_commit   = we_ok && !jr_bad;
  // A commit and a fetch in the same cycle fetch from the new PC.
  assign pc_new      = pc_commit ? next_pc : o_pc;
  assign start_fetch = i_start && (state != REQ);
  assign ack_take    = i_imem_ack && (state == REQ);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start)    state_nxt = REQ;
      REQ:     if (i_imem_ack) state_nxt = VALID;
      VALID:   if (i_start)    state_nxt = REQ;
      default:                 state_nxt = IDLE;
    endcase
  end

  // Output logic; req is a pure function of state so an async reset drops it at once.
  always_comb begin
    o_imem_req = (state == REQ);
    o_busy     = (state == REQ);
  end

  // Datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pc        <= RESET_PC;
      o_pc_plus4  <= RESET_PC + 32'd4;
      o_ir        <= 32'h0;
      o_ir_valid  <= 1'b0;
      o_imem_addr <= RESET_PC;
      o_misalign  <= 1'b0;
    end else begin
      o_misalign <= we_ok && jr_bad;
      o_pc       <= pc_new;
      if (start_fetch) begin
        o_imem_addr <= pc_new;
        o_ir_valid  <= 1'b0;
      end else if (ack_take) begin
        o_ir        <= i_imem_data;
        o_pc_plus4  <= o_pc + 32'd4;
        o_ir_valid  <= 1'b1;
      end else if (pc_commit) begin
        // IR no longer corresponds to PC.
        o_ir_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mc_fetch_unit.sv
// Purpose: directed self-checking bench for mc_fetch_unit.
// Latency: inputs driven 1 time unit after a rising edge, outputs sampled at the same point.
// Backpressure: imem ack is driven by hand, including delayed and late acks.
module tb_mc_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic [31:0] branch_off;
  logic [25:0] jump_idx;
  logic [31:0] jr_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] ir;
  logic        ir_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        busy;
  logic        misalign;

  int tests_run;
  int tests_failed;

  mc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_pc_we      (pc_we),
    .i_pc_sel     (pc_sel),
    .i_branch_off (branch_off),
    .i_jump_idx   (jump_idx),
    .i_jr_target  (jr_target),
    .o_imem_req   (imem_req),
    .o_imem_addr  (imem_addr),
    .i_imem_ack   (imem_ack),
    .i_imem_data  (imem_data),
    .o_ir         (ir),
    .o_ir_valid   (ir_valid),
    .o_pc         (pc),
    .o_pc_plus4   (pc_plus4),
    .o_busy       (busy),
    .o_misalign   (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    pc_we      = 1'b0;
    pc_sel     = 2'b00;
    branch_off = 32'h0;
    jump_idx   = 26'h0;
    jr_target  = 32'h0;
    imem_ack   = 1'b0;
    imem_data  = 32'h0;

    // Reset state
    #12;
    check_eq("rst_pc",       pc,        32'h0);
    check_eq("rst_pc_plus4", pc_plus4,  32'h4);
    check_eq("rst_ir",       ir,        32'h0);
    check_eq("rst_ir_valid", {31'b0, ir_valid}, 32'h0);
    check_eq("rst_req",      {31'b0, imem_req}, 32'h0);
    check_eq("rst_addr",     imem_addr, 32'h0);
    check_eq("rst_busy",     {31'b0, busy},     32'h0);
    check_eq("rst_misalign", {31'b0, misalign}, 32'h0);
    rst_n = 1'b1;

    // Fetch with zero-wait ack
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("f1_req",   {31'b0, imem_req}, 32'h1);
    check_eq("f1_busy",  {31'b0, busy},     32'h1);
    check_eq("f1_addr",  imem_addr,         32'h0);
    check_eq("f1_valid_low", {31'b0, ir_valid}, 32'h0);
    imem_ack  = 1'b1;
    imem_data = 32'hAAAA_0001;
    tick();
    imem_ack = 1'b0;
    check_eq("f1_req_drop", {31'b0, imem_req}, 32'h0);
    check_eq("f1_ir",       ir,                32'hAAAA_0001);
    check_eq("f1_valid",    {31'b0, ir_valid}, 32'h1);
    check_eq("f1_pc_plus4", pc_plus4,          32'h4);

    // Delayed ack, PC write during REQ is ignored
    start = 1'b1;
    tick();
    start  = 1'b0;
    pc_we  = 1'b1;
    pc_sel = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("f2_addr_hold", imem_addr,         32'h0);
      check_eq("f2_req_hold",  {31'b0, imem_req}, 32'h1);
      check_eq("f2_pc_frozen", pc,                32'h0);
    end
    pc_we     = 1'b0;
    imem_ack  = 1'b1;
    imem_data = 32'h0000_0002;
    tick();
    imem_ack = 1'b0;
    check_eq("f2_ir",    ir,                32'h0000_0002);
    check_eq("f2_valid", {31'b0, ir_valid}, 32'h1);
    check_eq("f2_pc",    pc,                32'h0);

    // jr to 0x100, fetch there
    pc_we     = 1'b1;
    pc_sel    = 2'b11;
    jr_target = 32'h0000_0100;
    tick();
    pc_we = 1'b0;
    check_eq("jr100_pc",    pc,                32'h0000_0100);
    check_eq("jr100_valid", {31'b0, ir_valid}, 32'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("f3_addr", imem_addr, 32'h0000_0100);
    imem_ack  = 1'b1;
    imem_data = 32'h1234_5678;
    tick();
    imem_ack = 1'b0;
    check_eq("f3_pc_plus4", pc_plus4, 32'h0000_0104);

    // Branch -2 words: 0x104 - 8 = 0xFC
    pc_we      = 1'b1;
    pc_sel     = 2'b01;
    branch_off = 32'hFFFF_FFFE;
    tick();
    check_eq("branch_pc",    pc,                32'h0000_00FC);
    check_eq("branch_valid", {31'b0, ir_valid}, 32'h0);
    // Jump idx 0x40 with upper bits of 0x104 -> 0x100
    pc_sel   = 2'b10;
    jump_idx = 26'h40;
    tick();
    check_eq("jump_pc", pc, 32'h0000_0100);

    // Misaligned jr rejected, then aligned jr
    pc_sel    = 2'b11;
    jr_target = 32'h0000_0202;
    tick();
    pc_we = 1'b0;
    check_eq("jrbad_pc",       pc,                32'h0000_0100);
    check_eq("jrbad_misalign", {31'b0, misalign}, 32'h1);
    tick();
    check_eq("jrbad_pulse_end", {31'b0, misalign}, 32'h0);
    pc_we     = 1'b1;
    jr_target = 32'h0000_0200;
    tick();
    pc_we = 1'b0;
    check_eq("jr200_pc",       pc,                32'h0000_0200);
    check_eq("jr200_misalign", {31'b0, misalign}, 32'h0);

    // Wrap: fetch at 0xFFFF_FFFC, seq commit gives 0
    pc_we     = 1'b1;
    jr_target = 32'hFFFF_FFFC;
    tick();
    pc_we = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    imem_ack  = 1'b1;
    imem_data = 32'hCAFE_F00D;
    tick();
    imem_ack = 1'b0;
    check_eq("wrap_pc_plus4", pc_plus4, 32'h0);
    pc_we  = 1'b1;
    pc_sel = 2'b00;
    tick();
    check_eq("wrap_pc", pc, 32'h0);

    // Commit and fetch in the same cycle fetch from the new PC
    pc_sel    = 2'b11;
    jr_target = 32'h0000_0300;
    start     = 1'b1;
    tick();
    pc_we = 1'b0;
    start = 1'b0;
    check_eq("wes_pc",   pc,                32'h0000_0300);
    check_eq("wes_addr", imem_addr,         32'h0000_0300);
    check_eq("wes_req",  {31'b0, imem_req}, 32'h1);

    // Async reset during REQ; late ack must be ignored
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("arst_req",  {31'b0, imem_req}, 32'h0);
    check_eq("arst_busy", {31'b0, busy},     32'h0);
    check_eq("arst_pc",   pc,                32'h0);
    imem_ack  = 1'b1;
    imem_data = 32'hDEAD_BEEF;
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("late_ack_ir",    ir,                32'h0);
    check_eq("late_ack_valid", {31'b0, ir_valid}, 32'h0);
    check_eq("late_ack_req",   {31'b0, imem_req}, 32'h0);
    imem_ack = 1'b0;
    tick();
    check_eq("late_ack_valid2", {31'b0, ir_valid}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
